counter_en_ctrl: RTL and testbench

- Upstream control stage for the 8-bit enable counter: generates its single-cycle `en` strobes.
- Programmable prescaler sets the strobe period.
- Two modes: continuous (free-run until stopped) or burst (exactly N strobes, then a completion pulse).
- Software/sequencer drives `start`/`stop`; the `en` output wires directly to the counter's enable.

---
 rtl/counter_en_ctrl.sv | 111 +++++++++++
 tb/tb_counter_en_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_en_ctrl.sv
// Enable-strobe generator for the 8-bit enable counter: a programmable prescaler
// produces single-cycle en strobes, either free-running or as a counted burst.
module counter_en_ctrl #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] rem
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mode_q, mode_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               en_q, en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      div_q   <= '0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    en_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          mode_d  = mode;
          div_d   = div;
          presc_d = div;
          if (mode && (burst_len == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            rem_d   = mode ? burst_len : '0;
          end
        end
      end
      StRun: begin
        // Abort wins over a strobe that is due on the same edge.
        if (stop) begin
          state_d = StIdle;
          rem_d   = '0;
        end else if (presc_q != '0) begin
          presc_d = presc_q - DIV_W'(1);
        end else begin
          en_d    = 1'b1;
          presc_d = div_q;
          if (mode_q) begin
            if (rem_q != '0) begin
              rem_d = rem_q - BURST_W'(1);
            end
            if (rem_q == BURST_W'(1)) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign en   = en_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign rem  = rem_q;

`ifdef ASSERTS_SV
  en_after_busy_a: assert property (@(posedge clk) disable iff (!rst_n) en |-> $past(busy));
  done_single_a:   assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  rem_idle_zero_a: assert property (@(posedge clk) disable iff (!rst_n)
                                    (!busy && !done) |-> (rem == '0));
  no_x_a:          assert property (@(posedge clk) disable iff (!rst_n)
                                    !$isunknown({en, busy, done}));
`endif

endmodule

// File: tb/tb_counter_en_ctrl.sv
// Bench for counter_en_ctrl: an edge-indexed model (strobe when the edge distance from
// start is a multiple of div+1) is compared every cycle, plus hand-computed spot checks.
module tb_counter_en_ctrl;

  localparam int DIV_W   = 8;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               mode;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst_len;
  logic               en;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] rem;

  int n_checks = 0;
  int n_pass   = 0;

  counter_en_ctrl #(
    .DIV_W  (DIV_W),
    .BURST_W(BURST_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .div      (div),
    .burst_len(burst_len),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .rem      (rem)
  );

  always #5 clk = ~clk;

  // Edge index: at posedge n this reads n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic m_busy, m_done, m_en, m_mode;
  int   m_rem, m_len, m_cnt, t0, period;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_en   <= 1'b0;
      m_rem  <= 0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (stop) begin
        m_busy <= 1'b0;
        m_en   <= 1'b0;
        m_rem  <= 0;
      end else if (((cyc - t0) % period) == 0) begin
        m_en  <= 1'b1;
        m_cnt <= m_cnt + 1;
        if (m_mode) begin
          m_rem <= m_len - (m_cnt + 1);
          if (m_cnt + 1 == m_len) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
        end
      end else begin
        m_en <= 1'b0;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_en   <= 1'b0;
    end else begin
      m_en <= 1'b0;
      if (start && !stop) begin
        t0     <= cyc;
        period <= int'(div) + 1;
        m_mode <= mode;
        m_len  <= int'(burst_len);
        m_cnt  <= 0;
        if (mode && burst_len == '0) begin
          m_done <= 1'b1;
          m_rem  <= 0;
        end else begin
          m_busy <= 1'b1;
          m_rem  <= mode ? int'(burst_len) : 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("model_en",   32'(en),   32'(m_en));
    check("model_busy", 32'(busy), 32'(m_busy));
    check("model_done", 32'(done), 32'(m_done));
    check("model_rem",  32'(rem),  32'(m_rem));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns just after the start edge E0.
  task automatic do_start(input logic md, input int d, input int bl);
    mode      = md;
    div       = DIV_W'(d);
    burst_len = BURST_W'(bl);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    mode = 1'b0;
    div = '0;
    burst_len = '0;
    #1;
    check("reset_en",   32'(en),   32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rem",  32'(rem),  32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Continuous, div=3: strobes after E4 and E8, stop sampled at E10.
    do_start(1'b0, 3, 0);
    check("cont_busy_e0", 32'(busy), 32'd1);
    tick(4);
    check("cont_en_e4", 32'(en), 32'd1);
    tick(1);
    check("cont_en_e5", 32'(en), 32'd0);
    tick(4);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("cont_stop_busy", 32'(busy), 32'd0);
    check("cont_stop_en",   32'(en),   32'd0);
    tick(6);

    // Burst back-to-back, div=0, len=5.
    do_start(1'b1, 0, 5);
    check("burst_rem_e0", 32'(rem), 32'd5);
    tick(1);
    check("burst_en_e1",  32'(en),  32'd1);
    check("burst_rem_e1", 32'(rem), 32'd4);
    tick(4);
    check("burst_en_e5",   32'(en),   32'd1);
    check("burst_done_e5", 32'(done), 32'd1);
    check("burst_rem_e5",  32'(rem),  32'd0);
    tick(1);
    check("burst_idle_e6", 32'({en, busy, done}), 32'd0);
    tick(3);

    // Zero-length burst.
    do_start(1'b1, 4, 0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    tick(1);
    check("zero_done_end", 32'(done), 32'd0);
    tick(3);

    // Async reset mid-burst, just after the 3rd strobe (E9).
    do_start(1'b1, 2, 10);
    tick(9);
    check("rst_en_before", 32'(en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_outputs", 32'({en, busy, done}), 32'd0);
    check("rst_rem",     32'(rem), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("rst_stay_idle", 32'(busy), 32'd0);

    // start+stop together in IDLE.
    mode = 1'b0;
    div = '0;
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    check("startstop_idle", 32'(busy), 32'd0);
    tick(3);

    // div=255 run, restart attempt with div=7 at E100, stop on the E512 strobe.
    do_start(1'b0, 255, 0);
    tick(99);
    mode = 1'b1;
    div = 8'd7;
    burst_len = 8'd3;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(156);
    check("ign_en_e256", 32'(en),  32'd1);
    check("ign_rem",     32'(rem), 32'd0);
    tick(255);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_due_en",   32'(en),   32'd0);
    check("stop_due_busy", 32'(busy), 32'd0);
    tick(4);

    // Max divisor burst of 2.
    do_start(1'b1, 255, 2);
    tick(256);
    check("max_en_e256",  32'(en),  32'd1);
    check("max_rem_e256", 32'(rem), 32'd1);
    tick(256);
    check("max_en_e512",   32'(en),   32'd1);
    check("max_done_e512", 32'(done), 32'd1);
    tick(1);
    check("max_idle", 32'({en, busy, done}), 32'd0);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
